alu_share_sched: RTL
====================

// Module: alu_share_sched
// PURPOSE
//  Shares the single ALU between two requesters (0: control unit, 1: user/debug port).
//  Arbitrates round-robin and latches the winner's operands.
//  Sequences the ALU: enable pulse, then BR readout via C9, then MR readout via C10 (MPY only).
//  Returns low/high results and flags to the winning requester with a one-cycle done pulse.
// PARAMETERS
//  WIDTH   16      operand/result width; matches ALU P/Q/BR/MR
//  OP_MPY  3'b010  ALU op code whose high half (MR) must be read back
//  RR_INIT 1'b0    requester favoured first after reset
// PORTS
//  i_clk         in   1      clock, all state on rising edge
//  i_rst_n       in   1      reset, asynchronous, active-low
//  i_req         in   2      per-requester request, level
//  i_op0/i_op1   in   3      ALU op code per requester
//  i_p0/i_p1     in   WIDTH  P operand per requester
//  i_q0/i_q1     in   WIDTH  Q operand per requester
//  i_flush       in   1      synchronous abort of the current job
//  o_gnt         out  2      one-hot grant pulse, one cycle
//  o_done        out  2      one-hot completion pulse, one cycle
//  o_res_low     out  WIDTH  captured BR; held until next capture
//  o_res_high    out  WIDTH  captured MR; 0 for non-MPY ops
//  o_res_flags   out  5      captured ALU flags {ZF,CF,OF,NF,MF}
//  o_busy        out  1      high in every state except IDLE
//  o_alu_p/o_alu_q  out  WIDTH  latched operands to ALU, held for the whole job
//  o_alu_op      out  3      latched op to ALU
//  o_alu_en      out  1      ALU update enable (ctrl_alu_en)
//  o_c9/o_c10    out  1      BR/MR bus-out controls to ALU
//  i_br/i_mr     in   WIDTH  ALU o_br / o_mr
//  i_flags       in   5      ALU o_flags
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=RR_INIT, all outputs 0, latched operands/op 0.
//   Asynchronous; mid-job reset drops the job with no done pulse.
//  FSM: IDLE -> EXEC -> RD_BR -> (RD_MR if op==OP_MPY) -> DONE -> IDLE.
//   IDLE: wait for any i_req. Single req wins. Both req: the rr-pointed requester wins.
//    On the same cycle: o_gnt[w]=1. Clock edge latches op/p/q/w and moves to EXEC.
//   EXEC: o_alu_en=1 for exactly one cycle; ALU writes BR (and MR if MPY).
//   RD_BR: o_c9=1. Edge captures i_br->o_res_low and i_flags->o_res_flags.
//    Also sets o_res_high=0. MPY goes to RD_MR, else to DONE.
//   RD_MR: o_c10=1. Edge captures i_mr->o_res_high.
//   DONE: o_done[w]=1 for one cycle. Edge sets rr pointer to ~w, state=IDLE.
//  o_alu_en, o_c9 and o_c10 are mutually exclusive; each is high in at most one state per job.
//  Latency, gnt cycle to done cycle: 3 cycles (non-MPY), 4 cycles (MPY).
//  Requests are sampled only in IDLE.
//   A requester may drop i_req after o_gnt.
//   A req still high in IDLE after its done counts as a new request.
//   The rr pointer guarantees alternation under contention.
//  Operand/op inputs are don't-care outside the grant cycle.
//  i_flush: in any non-IDLE state the next state is IDLE.
//   No o_done is issued and rr pointer and result registers are unchanged.
//   Asserting i_flush in IDLE does not block a grant that cycle.
//  Flags are the ALU's registered flags as presented in RD_BR; no recomputation here.
// TESTING
//  T1 ADD: req0, op=000, p=0x0003, q=0x0004 -> gnt0 @c0, alu_en @c1, c9 @c2.
//   done0 @c3 with low=0x0007, high=0x0000.
//  T2 MPY: req1, op=010, p=0x0100, q=0x0100 -> c10 @c3, done1 @c4.
//   low=0x0000, high=0x0001.
//  T3 contention: both req held from reset -> order req0, req1, req0.
//   Each done precedes the next gnt by 1 cycle; no overlap of en/c9/c10.
//  T4 flush: i_flush during RD_BR -> IDLE next cycle, no done.
//   o_res_low keeps its previous value and the pending requester is granted next.
//  T5 reset mid-EXEC: i_rst_n low -> all outputs 0 immediately.
//   After release, a fresh req0 completes normally.
//  T6 SUB: op=001, p=0x0005, q=0x0005 -> done with low=0x0000.
//   o_res_flags equals i_flags sampled in RD_BR.

Source files
------------

// File: rtl/alu_share_sched.sv
// Two-requester ALU share scheduler.
// Round-robin grant, operand latch, BR/MR readout sequencing.
module alu_share_sched #(
  parameter int          WIDTH   = 16,
  parameter logic [2:0]  OP_MPY  = 3'b010,
  parameter logic        RR_INIT = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_req,
  input  logic [2:0]       i_op0,
  input  logic [2:0]       i_op1,
  input  logic [WIDTH-1:0] i_p0,
  input  logic [WIDTH-1:0] i_p1,
  input  logic [WIDTH-1:0] i_q0,
  input  logic [WIDTH-1:0] i_q1,
  input  logic             i_flush,
  output logic [1:0]       o_gnt,
  output logic [1:0]       o_done,
  output logic [WIDTH-1:0] o_res_low,
  output logic [WIDTH-1:0] o_res_high,
  output logic [4:0]       o_res_flags,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_alu_p,
  output logic [WIDTH-1:0] o_alu_q,
  output logic [2:0]       o_alu_op,
  output logic             o_alu_en,
  output logic             o_c9,
  output logic             o_c10,
  input  logic [WIDTH-1:0] i_br,
  input  logic [WIDTH-1:0] i_mr,
  input  logic [4:0]       i_flags
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_RD_BR,
    S_RD_MR,
    S_DONE
  } state_t;

  state_t             state_q;
  logic               rr_q;
  logic               win_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   p_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic [4:0]         fl_q;
  logic               en_q;
  logic               c9_q;
  logic               c10_q;
  logic               busy_q;
  logic [1:0]         done_q;

  logic               win_d;
  logic [1:0]         gnt_d;

  // Arbitration: a lone requester wins, contention goes to the rr pointer.
  always_comb begin
    win_d = rr_q;
    gnt_d = 2'b00;
    unique case (1'b1)
      (i_req == 2'b01): win_d = 1'b0;
      (i_req == 2'b10): win_d = 1'b1;
      default:          win_d = rr_q;
    endcase
    if (i_rst_n && state_q == S_IDLE && (|i_req)) begin
      gnt_d = win_d ? 2'b10 : 2'b01;
    end
  end

  // Job sequencer with registered ALU controls, results and done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= RR_INIT;
      win_q   <= 1'b0;
      op_q    <= '0;
      p_q     <= '0;
      q_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      fl_q    <= '0;
      en_q    <= 1'b0;
      c9_q    <= 1'b0;
      c10_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 2'b00;
    end else begin
      en_q   <= 1'b0;
      c9_q   <= 1'b0;
      c10_q  <= 1'b0;
      done_q <= 2'b00;
      unique case (state_q)
        S_IDLE: begin
          if (|i_req) begin
            win_q   <= win_d;
            op_q    <= win_d ? i_op1 : i_op0;
            p_q     <= win_d ? i_p1 : i_p0;
            q_q     <= win_d ? i_q1 : i_q0;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (i_flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            c9_q    <= 1'b1;
            state_q <= S_RD_BR;
          end
        end
        S_RD_BR: begin
          if (i_flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            lo_q <= i_br;
            fl_q <= i_flags;
            hi_q <= '0;
            if (op_q == OP_MPY) begin
              c10_q   <= 1'b1;
              state_q <= S_RD_MR;
            end else begin
              done_q  <= win_q ? 2'b10 : 2'b01;
              state_q <= S_DONE;
            end
          end
        end
        S_RD_MR: begin
          if (i_flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            hi_q    <= i_mr;
            done_q  <= win_q ? 2'b10 : 2'b01;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!i_flush) begin
            rr_q <= ~win_q;
          end
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_gnt       = gnt_d;
  assign o_done      = done_q;
  assign o_res_low   = lo_q;
  assign o_res_high  = hi_q;
  assign o_res_flags = fl_q;
  assign o_busy      = busy_q;
  assign o_alu_p     = p_q;
  assign o_alu_q     = q_q;
  assign o_alu_op    = op_q;
  assign o_alu_en    = en_q;
  assign o_c9        = c9_q;
  assign o_c10       = c10_q;

endmodule
